async_fifo_wptr_ctrl: RTL and testbench
=======================================

Name: async_fifo_wptr_ctrl

Overview:
- Write-domain pointer and status controller for the team's dual-clock FIFO, parametrised in depth.
- Holds the binary write pointer and Gray write pointer, and synchronises the read-domain Gray pointer into clk.
- Generates registered full, almost-full, fill level and a sticky overflow flag.
- Drives the dual-port RAM write address and feeds the Gray pointer to the read-side controller.

Parameters:
- ADDR_W, 4, RAM address width; FIFO depth = 2**ADDR_W; pointers are ADDR_W+1 bits.
- SYNC_STAGES, 2, number of flops synchronising rptr_gray into clk; legal range 2..4.
- AFULL_THRESH, 12, level at or above which walmost_full asserts; legal range 1..2**ADDR_W.

Ports:
- clk  input  1  write-domain clock.
- rst  input  1  asynchronous, active-high reset.
- winc  input  1  write request; accepted only when wfull=0.
- rptr_gray  input  ADDR_W+1  read-domain Gray pointer, asynchronous to clk.
- wovf_clr  input  1  clears woverflow.
- waddr  output  ADDR_W  RAM write address (low bits of binary write pointer).
- wen  output  1  RAM write enable = winc & ~wfull (combinational).
- wptr_gray  output  ADDR_W+1  registered Gray write pointer, to the read domain.
- wfull  output  1  registered full flag.
- walmost_full  output  1  registered almost-full flag.
- wlevel  output  ADDR_W+1  registered entry count, 0..2**ADDR_W.
- woverflow  output  1  sticky flag: a write was attempted while full.

Behaviour:
- Reset (async assert, held while rst=1): wbin=0, wptr_gray=0, all synchroniser flops=0, wfull=0, walmost_full=0, wlevel=0, woverflow=0. waddr=0 follows from wbin.
- Synchroniser: SYNC_STAGES-deep flop chain on rptr_gray; the last stage is rq_gray. No logic between stages.
- rbin_sync = Gray-to-binary(rq_gray): bit i = XOR of rq_gray[ADDR_W:i].
- Next-state logic:
  - wbin_next = wbin + wen, modulo 2**(ADDR_W+1).
  - wgray_next = (wbin_next >> 1) ^ wbin_next.
- Every clk edge: wbin <= wbin_next; wptr_gray <= wgray_next.
- Full: wfull <= (wgray_next == {~rq_gray[ADDR_W:ADDR_W-1], rq_gray[ADDR_W-2:0]}). The top two bits are inverted; this is the correct Gray-domain full compare.
- Level: lvl_next = wbin_next - rbin_sync, modulo 2**(ADDR_W+1).
  - wlevel <= lvl_next.
  - walmost_full <= (lvl_next >= AFULL_THRESH).
- Flag latency and pessimism:
  - wfull, wlevel and walmost_full reflect an accepted write on the same edge that advances the pointer.
  - They reflect a read-side pointer change SYNC_STAGES+1 clk edges after rptr_gray changes.
  - Levels are pessimistic: never below the true count.
- Full boundary: while wfull=1, winc is ignored. Pointers hold, wen=0.
- Overflow:
  - woverflow <= 1 when winc & wfull.
  - Otherwise it clears when wovf_clr=1, and holds in all other cases.
  - If set and clear occur in the same cycle, set wins.
- Wrap-around:
  - waddr wraps from 2**ADDR_W-1 to 0.
  - The pointer MSB toggles every 2**ADDR_W accepted writes.
  - Gray sequence is continuous across the wrap (Gray 0x10 -> 0x00 for ADDR_W=4).
- Simultaneous write and read-pointer update in one cycle: both take effect in lvl_next. wfull may drop and re-assert correctly in consecutive cycles.
- Reset mid-operation: all state returns to reset values immediately, regardless of clk. The read side must be reset concurrently; this is a system requirement, not checked here.
- Only one wptr_gray bit changes per clk edge, and wptr_gray is driven directly from a flop.

Test Plan:
1. Reset, then 16 back-to-back winc with rptr_gray=0 (ADDR_W=4, AFULL_THRESH=12):
   - walmost_full rises on the 12th write edge.
   - wfull rises on the 16th write edge, with wlevel=16, wptr_gray=0x18, waddr=0.
2. Full, then winc held 3 cycles:
   - wen=0 and wptr_gray stays 0x18.
   - woverflow=1 from the first edge and stays after winc drops.
   - Pulse wovf_clr: woverflow=0 the next edge.
   - Assert winc and wovf_clr together while full: woverflow stays 1.
3. Full, then rptr_gray set to 0x01 (Gray of 1):
   - wfull falls and wlevel=15 exactly SYNC_STAGES+1 (=3) edges later, not earlier.
4. Wrap: 40 writes, with rptr_gray following Gray(wbin-2) through the synchroniser:
   - wptr_gray follows Gray(n) every edge, with exactly one bit change per edge.
   - Pointer goes 0x10 -> 0x00 at binary 31 -> 32.
   - wfull never asserts; wlevel never exceeds 2 + SYNC_STAGES + 1.
5. Write 10 entries, assert rst asynchronously between clk edges:
   - All outputs 0 before the next edge.
   - After release, the first write yields wptr_gray=0x01, wlevel=1.
6. Parameter sweep ADDR_W=2 and ADDR_W=6, SYNC_STAGES=3:
   - wfull asserts at exactly 4 and 64 writes respectively with reads stalled.
   - walmost_full asserts at AFULL_THRESH.

Source files
------------

// File: rtl/async_fifo_wptr_ctrl.sv
// Write-domain pointer/status controller for the dual-clock FIFO.
// Owns the binary/Gray write pointers, synchronises the read Gray pointer and derives full/level flags.
module async_fifo_wptr_ctrl #(
    parameter int ADDR_W       = 4,
    parameter int SYNC_STAGES  = 2,
    parameter int AFULL_THRESH = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              winc,
    input  logic [ADDR_W:0]   rptr_gray,
    input  logic              wovf_clr,
    output logic [ADDR_W-1:0] waddr,
    output logic              wen,
    output logic [ADDR_W:0]   wptr_gray,
    output logic              wfull,
    output logic              walmost_full,
    output logic [ADDR_W:0]   wlevel,
    output logic              woverflow
);

    localparam logic [ADDR_W:0] AFULL_LVL = (ADDR_W + 1)'(AFULL_THRESH);

    logic [ADDR_W:0] sync_q [SYNC_STAGES];
    logic [ADDR_W:0] rq_gray;
    logic [ADDR_W:0] rbin_sync;
    logic [ADDR_W:0] wbin;
    logic [ADDR_W:0] wbin_next;
    logic [ADDR_W:0] wgray_next;
    logic [ADDR_W:0] lvl_next;
    logic            full_next;

    // NOTE: the synchroniser is a plain flop chain with async reset on every stage;
    // no logic may sit between stages or metastability can propagate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= rptr_gray;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign rq_gray = sync_q[SYNC_STAGES-1];

    // NOTE: every bit is assigned on every pass, so this block cannot infer a latch.
    always_comb begin
        for (int i = 0; i <= ADDR_W; i++) rbin_sync[i] = ^(rq_gray >> i);
    end

    assign wen        = winc & ~wfull;
    assign wbin_next  = wbin + {{ADDR_W{1'b0}}, wen};
    assign wgray_next = (wbin_next >> 1) ^ wbin_next;
    // Full when the write pointer is exactly one lap ahead: top two Gray bits differ, rest equal.
    assign full_next  = (wgray_next == {~rq_gray[ADDR_W:ADDR_W-1], rq_gray[ADDR_W-2:0]});
    assign lvl_next   = wbin_next - rbin_sync;

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wbin         <= '0;
            wptr_gray    <= '0;
            wfull        <= 1'b0;
            walmost_full <= 1'b0;
            wlevel       <= '0;
            woverflow    <= 1'b0;
        end else begin
            wbin         <= wbin_next;
            wptr_gray    <= wgray_next;
            wfull        <= full_next;
            walmost_full <= (lvl_next >= AFULL_LVL);
            wlevel       <= lvl_next;
            // A rejected write outranks a simultaneous clear.
            if (winc && wfull) woverflow <= 1'b1;
            else if (wovf_clr) woverflow <= 1'b0;
        end
    end

    assign waddr = wbin[ADDR_W-1:0];

endmodule

// File: tb/tb_async_fifo_wptr_ctrl.sv
// Self-checking bench for async_fifo_wptr_ctrl: count-based reference model plus directed scenarios.
// Main instance is ADDR_W=4/SYNC=2/THRESH=12; two extra instances cover the depth sweep.
module tb_async_fifo_wptr_ctrl;

    localparam int SYNC  = 2;
    localparam int DEPTH = 16;
    localparam int MODW  = 32;

    logic       clk = 1'b0;
    logic       rst;
    logic       winc, wovf_clr;
    logic [4:0] rptr_gray;
    logic [3:0] waddr;
    logic       wen, wfull, walmost_full, woverflow;
    logic [4:0] wptr_gray, wlevel;

    logic       winc2, wen2, wfull2, wafull2, wovf2;
    logic [2:0] rptr2, wgray2, wlevel2;
    logic [1:0] waddr2;
    logic       winc6, wen6, wfull6, wafull6, wovf6;
    logic [6:0] rptr6, wgray6, wlevel6;
    logic [5:0] waddr6;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    async_fifo_wptr_ctrl #(.ADDR_W(4), .SYNC_STAGES(SYNC), .AFULL_THRESH(12)) dut (
        .clk(clk), .rst(rst), .winc(winc), .rptr_gray(rptr_gray), .wovf_clr(wovf_clr),
        .waddr(waddr), .wen(wen), .wptr_gray(wptr_gray), .wfull(wfull),
        .walmost_full(walmost_full), .wlevel(wlevel), .woverflow(woverflow));

    async_fifo_wptr_ctrl #(.ADDR_W(2), .SYNC_STAGES(3), .AFULL_THRESH(3)) dut_a2 (
        .clk(clk), .rst(rst), .winc(winc2), .rptr_gray(rptr2), .wovf_clr(1'b0),
        .waddr(waddr2), .wen(wen2), .wptr_gray(wgray2), .wfull(wfull2),
        .walmost_full(wafull2), .wlevel(wlevel2), .woverflow(wovf2));

    async_fifo_wptr_ctrl #(.ADDR_W(6), .SYNC_STAGES(3), .AFULL_THRESH(48)) dut_a6 (
        .clk(clk), .rst(rst), .winc(winc6), .rptr_gray(rptr6), .wovf_clr(1'b0),
        .waddr(waddr6), .wen(wen6), .wptr_gray(wgray6), .wfull(wfull6),
        .walmost_full(wafull6), .wlevel(wlevel6), .woverflow(wovf6));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int gray(input int n);
        return n ^ (n >> 1);
    endfunction

    function automatic int g2b(input logic [4:0] g);
        int b = 0;
        for (int i = 0; i < 5; i++) b = b ^ int'(g >> i);
        return b;
    endfunction

    // Reference model: accepted-write count and delayed view of the read count, both mod 32.
    int   m_wr, m_level, m_acc, m_wr_next, m_lvl_next;
    int   m_rhist [SYNC];
    logic m_ovf;

    always_comb begin
        m_acc      = (winc && m_level != DEPTH) ? 1 : 0;
        m_wr_next  = (m_wr + m_acc) % MODW;
        m_lvl_next = (m_wr_next - m_rhist[SYNC-1] + MODW) % MODW;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_wr    <= 0;
            m_level <= 0;
            m_ovf   <= 1'b0;
            for (int i = 0; i < SYNC; i++) m_rhist[i] <= 0;
        end else begin
            m_wr    <= m_wr_next;
            m_level <= m_lvl_next;
            m_ovf   <= (winc && m_level == DEPTH) ? 1'b1 : (wovf_clr ? 1'b0 : m_ovf);
            m_rhist[0] <= g2b(rptr_gray);
            for (int i = 1; i < SYNC; i++) m_rhist[i] <= m_rhist[i-1];
        end
    end

    logic [4:0] prev_gray = '0;

    always @(negedge clk) begin
        if (chk_en) begin
            check("m_wfull",  32'(wfull),        32'(m_level == DEPTH));
            check("m_afull",  32'(walmost_full), 32'(m_level >= 12));
            check("m_wlevel", 32'(wlevel),       32'(m_level));
            check("m_wgray",  32'(wptr_gray),    32'(gray(m_wr)));
            check("m_waddr",  32'(waddr),        32'(m_wr % DEPTH));
            check("m_wen",    32'(wen),          32'(winc && m_level != DEPTH));
            check("m_wovf",   32'(woverflow),    32'(m_ovf));
            if (!rst) check("gray_1bit", 32'($countones(wptr_gray ^ prev_gray) <= 1), 32'd1);
        end
        prev_gray <= rst ? 5'd0 : wptr_gray;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        rst = 1'b1; winc = 1'b0; wovf_clr = 1'b0; rptr_gray = '0;
        winc2 = 1'b0; winc6 = 1'b0; rptr2 = '0; rptr6 = '0;
        #12;
        check("rst_wgray", 32'(wptr_gray), 32'd0);
        check("rst_waddr", 32'(waddr), 32'd0);
        check("rst_state", 32'({wfull, walmost_full, woverflow, wen}), 32'd0);
        check("rst_wlevel", 32'(wlevel), 32'd0);
        rst = 1'b0;
        chk_en = 1'b1;

        // 16 back-to-back writes, reads stalled
        winc = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            check("p1_lvl", 32'(wlevel), 32'(i));
            check("p1_afull", 32'(walmost_full), 32'(i >= 12));
            check("p1_full", 32'(wfull), 32'(i == 16));
        end
        check("p1_gray", 32'(wptr_gray), 32'h18);
        check("p1_waddr", 32'(waddr), 32'd0);

        // writes while full
        for (int i = 0; i < 3; i++) begin
            tick();
            check("p2_wen", 32'(wen), 32'd0);
            check("p2_gray", 32'(wptr_gray), 32'h18);
            check("p2_ovf", 32'(woverflow), 32'd1);
        end
        winc = 1'b0;
        tick();
        check("p2_ovf_hold", 32'(woverflow), 32'd1);
        wovf_clr = 1'b1;
        tick();
        check("p2_ovf_clr", 32'(woverflow), 32'd0);
        winc = 1'b1;
        tick();
        check("p2_ovf_set_wins", 32'(woverflow), 32'd1);
        winc = 1'b0; wovf_clr = 1'b0;

        // one read becomes visible after SYNC+1 edges
        rptr_gray = 5'h01;
        tick(); check("p3_full_e1", 32'(wfull), 32'd1); check("p3_lvl_e1", 32'(wlevel), 32'd16);
        tick(); check("p3_full_e2", 32'(wfull), 32'd1); check("p3_lvl_e2", 32'(wlevel), 32'd16);
        tick(); check("p3_full_e3", 32'(wfull), 32'd0); check("p3_lvl_e3", 32'(wlevel), 32'd15);

        // wrap with read pointer trailing two behind
        rptr_gray = 5'(gray(14));
        repeat (4) tick();
        check("p4_lvl_start", 32'(wlevel), 32'd2);
        n = 16;
        winc = 1'b1;
        for (int k = 0; k < 40; k++) begin
            tick();
            n++;
            check("p4_gray", 32'(wptr_gray), 32'(gray(n % MODW)));
            check("p4_nofull", 32'(wfull), 32'd0);
            check("p4_lvl_bound", 32'(wlevel <= 5'd5), 32'd1);
            if (n == 31) check("p4_gray31", 32'(wptr_gray), 32'h10);
            if (n == 32) check("p4_gray32", 32'(wptr_gray), 32'h00);
            rptr_gray = 5'(gray((n - 2) % MODW));
        end

        // async reset between edges
        for (int k = 0; k < 10; k++) begin
            tick();
            n++;
            rptr_gray = 5'(gray((n - 2) % MODW));
        end
        #2;
        rst = 1'b1; winc = 1'b0; rptr_gray = '0;
        #1;
        check("p5_gray", 32'(wptr_gray), 32'd0);
        check("p5_waddr", 32'(waddr), 32'd0);
        check("p5_lvl", 32'(wlevel), 32'd0);
        check("p5_flags", 32'({wfull, walmost_full, woverflow}), 32'd0);
        tick();
        #2;
        rst = 1'b0;
        winc = 1'b1;
        tick();
        check("p5_gray_first", 32'(wptr_gray), 32'h01);
        check("p5_lvl_first", 32'(wlevel), 32'd1);
        winc = 1'b0;
        tick();

        // depth sweep, reads stalled
        winc2 = 1'b1; winc6 = 1'b1;
        for (int i = 1; i <= 64; i++) begin
            tick();
            check("p6_a2_full", 32'(wfull2), 32'(i >= 4));
            check("p6_a2_afull", 32'(wafull2), 32'(i >= 3));
            check("p6_a2_lvl", 32'(wlevel2), 32'(i < 4 ? i : 4));
            check("p6_a6_full", 32'(wfull6), 32'(i >= 64));
            check("p6_a6_afull", 32'(wafull6), 32'(i >= 48));
            check("p6_a6_lvl", 32'(wlevel6), 32'(i));
        end
        winc2 = 1'b0; winc6 = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
